// File: rtl/l1an_hdr_reader_pkg.sv
// l1an_hdr_reader_pkg
// Shared definitions for the L1A-number FIFO header reader:
//   - FSM state encoding
//   - header marker nibbles and header word count
//   - the packed register bundle. When TMR=1 it is triplicated and voted as one unit.
//   - a helper that builds one header word from the captured event fields
package l1an_hdr_reader_pkg;

    localparam int         HDR_WORDS = 3;
    localparam logic [1:0] LAST_IDX  = 2'd2;

    localparam logic [3:0] W0_MARK = 4'h9;
    localparam logic [3:0] W1_MARK = 4'hA;
    localparam logic [3:0] W2_MARK = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_POP    = 3'd2,
        ST_SEND   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    typedef struct packed {
        state_t      state;
        logic [1:0]  widx;
        logic [5:0]  num;
        logic        phase;
        logic        mism;
        logic [5:0]  expn;
        logic        exp_valid;
        logic        seq_err;
        logic [5:0]  evt_cnt;
        logic        hdr_dv;
        logic [15:0] hdr_data;
        logic        hdr_last;
    } regs_t;

    function automatic logic [15:0] hdr_word(input logic [1:0] idx,
                                             input logic [5:0] num,
                                             input logic       phase,
                                             input logic [5:0] cnt,
                                             input logic       mism);
        case (idx)
            2'd0:    hdr_word = {W0_MARK, 6'h00, num};
            2'd1:    hdr_word = {W1_MARK, 5'h00, phase, cnt};
            default: hdr_word = {W2_MARK, 11'h000, mism};
        endcase
    endfunction

endpackage

// File: rtl/l1an_hdr_reader_vote.sv
// l1an_hdr_reader_vote
// Bitwise 2-of-3 majority voter.
//   a, b, c : replica inputs, Width bits each
//   y       : voted output, Width bits
module l1an_hdr_reader_vote #(
    parameter int Width = 1
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    input  logic [Width-1:0] c,
    output logic [Width-1:0] y
);
    assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/l1an_hdr_reader.sv
// l1an_hdr_reader
// Consumer end of the L1A-number FIFO.
// The reader waits for the FIFO to be non-empty and allows one cycle for the
// RAM read data to settle. It then pops one entry and sends a 3-word event
// header over a valid/ready handshake. It also checks the L1A numbers for
// continuity (mod 64).
//
// state  | meaning
// IDLE   | waiting for FIFO_EMPTY=0 (only state that samples it)
// SETTLE | one cycle for the synchronous-read RAM output to settle
// POP    | FIFO_POP strobe; capture number/phase, sequence check, count
// SEND   | present header words 0..2, advance on HDR_DV & HDR_RDY
// HOLD   | one cycle for the FIFO's registered EMPTY to catch up
//
// Ports:
//   CLK, RST (sync, active-high)
//   FIFO_EMPTY, L1ANUM[5:0], L1A_PHASE  : FIFO read side
//   FIFO_POP                            : one-cycle pop strobe
//   HDR_RDY, HDR_DV, HDR_DATA[15:0], HDR_LAST : header stream
//   BUSY     : state != IDLE
//   SEQ_ERR  : sticky number discontinuity flag
//   EVT_CNT  : events popped since reset, wraps 63->0
module l1an_hdr_reader
    import l1an_hdr_reader_pkg::*;
#(
    parameter int TMR  = 0,
    parameter int NHDR = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FIFO_EMPTY,
    input  logic [5:0]  L1ANUM,
    input  logic        L1A_PHASE,
    output logic        FIFO_POP,
    input  logic        HDR_RDY,
    output logic        HDR_DV,
    output logic [15:0] HDR_DATA,
    output logic        HDR_LAST,
    output logic        BUSY,
    output logic        SEQ_ERR,
    output logic [5:0]  EVT_CNT
);

    localparam int NREP = (TMR != 0) ? 3 : 1;

    if (NHDR != HDR_WORDS) begin : g_bad_nhdr
        $error("l1an_hdr_reader: NHDR must be 3");
    end

    regs_t cur;
    regs_t nxt;

    always_comb begin
        nxt = cur;
        case (cur.state)
            ST_IDLE: begin
                if (!FIFO_EMPTY) nxt.state = ST_SETTLE;
            end
            ST_SETTLE: begin
                nxt.state = ST_POP;
            end
            ST_POP: begin
                nxt.num       = L1ANUM;
                nxt.phase     = L1A_PHASE;
                // The first event after reset only sets the reference.
                nxt.mism      = cur.exp_valid && (L1ANUM != cur.expn);
                // The reference always follows the last number, so a single gap is flagged once.
                nxt.expn      = L1ANUM + 6'd1;
                nxt.exp_valid = 1'b1;
                nxt.seq_err   = cur.seq_err | nxt.mism;
                nxt.evt_cnt   = cur.evt_cnt + 6'd1;
                nxt.widx      = 2'd0;
                nxt.hdr_dv    = 1'b1;
                nxt.hdr_last  = 1'b0;
                nxt.hdr_data  = hdr_word(2'd0, L1ANUM, L1A_PHASE, nxt.evt_cnt, nxt.mism);
                nxt.state     = ST_SEND;
            end
            ST_SEND: begin
                if (HDR_RDY) begin
                    if (cur.widx == LAST_IDX) begin
                        nxt.widx     = 2'd0;
                        nxt.hdr_dv   = 1'b0;
                        nxt.hdr_last = 1'b0;
                        nxt.hdr_data = 16'h0000;
                        nxt.state    = ST_HOLD;
                    end else begin
                        nxt.widx     = cur.widx + 2'd1;
                        nxt.hdr_data = hdr_word(nxt.widx, cur.num, cur.phase,
                                                cur.evt_cnt, cur.mism);
                        nxt.hdr_last = (nxt.widx == LAST_IDX);
                    end
                end
            end
            ST_HOLD: begin
                nxt.state = ST_IDLE;
            end
            default: begin
                nxt.state = ST_IDLE;
            end
        endcase
    end

    // Each replica loads the same next value. The next value is computed from
    // the voted state, so an upset replica resynchronises on the following edge.
    for (genvar r = 0; r < NREP; r++) begin : g_rep
        regs_t q;
        always_ff @(posedge CLK) begin
            if (RST) q <= '0;
            else     q <= nxt;
        end
    end

    if (TMR != 0) begin : g_tmr
        logic [$bits(regs_t)-1:0] voted;
        l1an_hdr_reader_vote #(.Width($bits(regs_t))) u_vote (
            .a (g_rep[0].q),
            .b (g_rep[1].q),
            .c (g_rep[2].q),
            .y (voted)
        );
        assign cur = voted;
    end else begin : g_single
        assign cur = g_rep[0].q;
    end

    assign FIFO_POP = (cur.state == ST_POP);
    assign BUSY     = (cur.state != ST_IDLE);
    assign HDR_DV   = cur.hdr_dv;
    assign HDR_DATA = cur.hdr_data;
    assign HDR_LAST = cur.hdr_last;
    assign SEQ_ERR  = cur.seq_err;
    assign EVT_CNT  = cur.evt_cnt;

endmodule
